// File: rtl/tft_timing_gen.sv
// Raster timing generator for the TFT pixel-clock domain: syncs, data enable and line-buffer read controls.
// Optional sticky frame interrupt is built when TFT_VSYNC_IRQ_EN is defined.
module tft_timing_gen #(
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10
) (
  input  logic tft_clk,
  input  logic tft_rst_n,
  input  logic tft_on_reg,
`ifdef TFT_VSYNC_IRQ_EN
  input  logic vsync_irq_ack,
  output logic vsync_irq,
`endif
  output logic HSYNC,
  output logic VSYNC,
  output logic DE,
  output logic BRAM_TFT_rd,
  output logic BRAM_TFT_oe,
  output logic get_line_start,
  output logic frame_start
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HA0     = H_SYNC + H_BP;
  localparam int VA0     = V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_MAX      = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNC_END = HW'(H_SYNC);
  localparam logic [HW-1:0] H_DE_FIRST = HW'(HA0);
  localparam logic [HW-1:0] H_DE_LAST  = HW'(HA0 + H_ACTIVE - 1);
  localparam logic [HW-1:0] H_OE_FIRST = HW'(HA0 - 1);
  localparam logic [HW-1:0] H_OE_LAST  = HW'(HA0 + H_ACTIVE - 2);
  localparam logic [HW-1:0] H_RD_FIRST = HW'(HA0 - 2);
  localparam logic [HW-1:0] H_RD_LAST  = HW'(HA0 + H_ACTIVE - 3);
  localparam logic [HW-1:0] H_FP_FIRST = HW'(HA0 + H_ACTIVE);
  localparam logic [VW-1:0] V_MAX      = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SYNC_END = VW'(V_SYNC);
  localparam logic [VW-1:0] V_DE_FIRST = VW'(VA0);
  localparam logic [VW-1:0] V_DE_LAST  = VW'(VA0 + V_ACTIVE - 1);

  // The read strobe leads DE by two cycles, so it must not reach back into the previous line.
  if (HA0 < 2) begin : g_ha0_check
    $error("tft_timing_gen: H_SYNC + H_BP must be at least 2");
  end

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic [VW-1:0] v_next;
  logic          v_active, v_next_active;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          rd_q, rd_d;
  logic          oe_q, oe_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;
`ifdef TFT_VSYNC_IRQ_EN
  logic          irq_q, irq_d;
`endif

  always_comb begin
    v_next        = (v_cnt_q == V_MAX) ? '0 : v_cnt_q + VW'(1);
    v_active      = (v_cnt_q >= V_DE_FIRST) && (v_cnt_q <= V_DE_LAST);
    v_next_active = (v_next >= V_DE_FIRST) && (v_next <= V_DE_LAST);

    h_cnt_d       = (h_cnt_q == H_MAX) ? '0 : h_cnt_q + HW'(1);
    v_cnt_d       = (h_cnt_q == H_MAX) ? v_next : v_cnt_q;
    hsync_d       = (h_cnt_q >= H_SYNC_END);
    vsync_d       = (v_cnt_q >= V_SYNC_END);
    de_d          = v_active && (h_cnt_q >= H_DE_FIRST) && (h_cnt_q <= H_DE_LAST);
    oe_d          = v_active && (h_cnt_q >= H_OE_FIRST) && (h_cnt_q <= H_OE_LAST);
    rd_d          = v_active && (h_cnt_q >= H_RD_FIRST) && (h_cnt_q <= H_RD_LAST);
    line_start_d  = v_next_active && (h_cnt_q == H_FP_FIRST);
    frame_start_d = (h_cnt_q == '0) && (v_cnt_q == '0);
`ifdef TFT_VSYNC_IRQ_EN
    irq_d = irq_q;
    if (frame_start_d)      irq_d = 1'b1;
    else if (vsync_irq_ack) irq_d = 1'b0;
`endif

    // Display disabled looks exactly like reset so re-enable starts a clean frame.
    if (!tft_on_reg) begin
      h_cnt_d       = '0;
      v_cnt_d       = '0;
      hsync_d       = 1'b1;
      vsync_d       = 1'b1;
      de_d          = 1'b0;
      oe_d          = 1'b0;
      rd_d          = 1'b0;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;
`ifdef TFT_VSYNC_IRQ_EN
      irq_d         = 1'b0;
`endif
    end
  end

  always_ff @(posedge tft_clk) begin
    if (!tft_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      de_q          <= 1'b0;
      oe_q          <= 1'b0;
      rd_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef TFT_VSYNC_IRQ_EN
      irq_q         <= 1'b0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      oe_q          <= oe_d;
      rd_q          <= rd_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
`ifdef TFT_VSYNC_IRQ_EN
      irq_q         <= irq_d;
`endif
    end
  end

  assign HSYNC          = hsync_q;
  assign VSYNC          = vsync_q;
  assign DE             = de_q;
  assign BRAM_TFT_rd    = rd_q;
  assign BRAM_TFT_oe    = oe_q;
  assign get_line_start = line_start_q;
  assign frame_start    = frame_start_q;
`ifdef TFT_VSYNC_IRQ_EN
  assign vsync_irq      = irq_q;
`endif

endmodule

// File: tb/tb_tft_timing_gen.sv
// Directed bench for tft_timing_gen: a small 15x8 raster plus a default 800x525 instance.
// The interrupt scenario is compiled in only when TFT_VSYNC_IRQ_EN is defined.
module tb_tft_timing_gen;

  logic tft_clk = 1'b0;
  logic tft_rst_n;
  logic tft_on_reg;
  logic hsync, vsync, de, rd, oe, gls, fs;
  logic d_hsync, d_vsync, d_de, d_rd, d_oe, d_gls, d_fs;
`ifdef TFT_VSYNC_IRQ_EN
  logic irq_ack, irq, d_irq;
  logic d_irq_ack;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int pos      = 0;

  always #5 tft_clk = ~tft_clk;

  tft_timing_gen #(
    .H_SYNC(2), .H_BP(3), .H_ACTIVE(8), .H_FP(2),
    .V_SYNC(1), .V_BP(2), .V_ACTIVE(4), .V_FP(1)
  ) dut (
    .tft_clk(tft_clk), .tft_rst_n(tft_rst_n), .tft_on_reg(tft_on_reg),
`ifdef TFT_VSYNC_IRQ_EN
    .vsync_irq_ack(irq_ack), .vsync_irq(irq),
`endif
    .HSYNC(hsync), .VSYNC(vsync), .DE(de), .BRAM_TFT_rd(rd), .BRAM_TFT_oe(oe),
    .get_line_start(gls), .frame_start(fs)
  );

  tft_timing_gen dut_default (
    .tft_clk(tft_clk), .tft_rst_n(tft_rst_n), .tft_on_reg(tft_on_reg),
`ifdef TFT_VSYNC_IRQ_EN
    .vsync_irq_ack(d_irq_ack), .vsync_irq(d_irq),
`endif
    .HSYNC(d_hsync), .VSYNC(d_vsync), .DE(d_de), .BRAM_TFT_rd(d_rd), .BRAM_TFT_oe(d_oe),
    .get_line_start(d_gls), .frame_start(d_fs)
  );

  // pos is the raster position whose outputs are visible after the latest edge.
  task automatic tick();
    @(posedge tft_clk);
    @(negedge tft_clk);
    pos++;
  endtask

  task automatic advance_to(input int target);
    while (pos < target) tick();
  endtask

  task automatic test_reset();
    tft_rst_n = 1'b0;
    tft_on_reg = 1'b1;
    tick();
    tick();
    n_checks++;
    if ({hsync, vsync, de, rd, oe, gls, fs} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 1100000", {hsync, vsync, de, rd, oe, gls, fs});
    end
    n_checks++;
    if ({d_hsync, d_vsync, d_de, d_rd, d_oe, d_gls, d_fs} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL reset_outputs_default: got %b expected 1100000",
               {d_hsync, d_vsync, d_de, d_rd, d_oe, d_gls, d_fs});
    end
    tft_rst_n = 1'b1;
    tick();
    pos = 0;
    n_checks++;
    if ({hsync, vsync, fs} !== 3'b001) begin
      n_fail++;
      $display("FAIL release_frame_start: hsync/vsync/fs got %b expected 001", {hsync, vsync, fs});
    end
  endtask

  task automatic test_sync();
    int hs_low = 1;
    int vs_low = 1;
    int fs_cnt = 1;
    for (int i = 1; i < 120; i++) begin
      tick();
      hs_low += (hsync == 1'b0) ? 1 : 0;
      vs_low += (vsync == 1'b0) ? 1 : 0;
      fs_cnt += (fs == 1'b1) ? 1 : 0;
      n_checks++;
      if (hsync !== ((pos % 15) >= 2)) begin
        n_fail++;
        $display("FAIL hsync_pos%0d: got %b expected %b", pos, hsync, (pos % 15) >= 2);
      end
      n_checks++;
      if (vsync !== ((pos / 15) >= 1)) begin
        n_fail++;
        $display("FAIL vsync_pos%0d: got %b expected %b", pos, vsync, (pos / 15) >= 1);
      end
    end
    n_checks++;
    if (hs_low !== 16) begin
      n_fail++;
      $display("FAIL hsync_low_count: got %0d expected 16", hs_low);
    end
    n_checks++;
    if (vs_low !== 15) begin
      n_fail++;
      $display("FAIL vsync_low_count: got %0d expected 15", vs_low);
    end
    n_checks++;
    if (fs_cnt !== 1) begin
      n_fail++;
      $display("FAIL frame_start_count: got %0d expected 1", fs_cnt);
    end
    tick();
    n_checks++;
    if (fs !== 1'b1) begin
      n_fail++;
      $display("FAIL second_frame_start: got %b expected 1", fs);
    end
  endtask

  task automatic test_active_line();
    int rd_cnt = 0;
    int oe_cnt = 0;
    int de_cnt = 0;
    int h;
    advance_to(164);
    for (int i = 0; i < 15; i++) begin
      tick();
      h = pos % 15;
      rd_cnt += rd ? 1 : 0;
      oe_cnt += oe ? 1 : 0;
      de_cnt += de ? 1 : 0;
      n_checks++;
      if ({rd, oe, de} !== {(h >= 3 && h <= 10), (h >= 4 && h <= 11), (h >= 5 && h <= 12)}) begin
        n_fail++;
        $display("FAIL line3_h%0d rd/oe/de: got %b expected %b", h, {rd, oe, de},
                 {(h >= 3 && h <= 10), (h >= 4 && h <= 11), (h >= 5 && h <= 12)});
      end
    end
    n_checks++;
    if ({rd_cnt, oe_cnt, de_cnt} !== {32'd8, 32'd8, 32'd8}) begin
      n_fail++;
      $display("FAIL line3_counts: rd %0d oe %0d de %0d expected 8 each", rd_cnt, oe_cnt, de_cnt);
    end
  endtask

  task automatic test_line_start();
    int exp_v[4] = '{2, 3, 4, 5};
    int gls_cnt = 0;
    int de_cnt  = 0;
    int h, v;
    advance_to(239);
    for (int i = 0; i < 120; i++) begin
      tick();
      h = pos % 15;
      v = (pos % 120) / 15;
      de_cnt += de ? 1 : 0;
      if (gls) begin
        n_checks++;
        if (gls_cnt >= 4 || h !== 13 || v !== exp_v[gls_cnt < 4 ? gls_cnt : 0]) begin
          n_fail++;
          $display("FAIL line_start_%0d: got h=%0d v=%0d expected h=13 v=%0d", gls_cnt, h, v,
                   exp_v[gls_cnt < 4 ? gls_cnt : 0]);
        end
        gls_cnt++;
      end
      if (v < 3 || v > 6) begin
        n_checks++;
        if ({de, rd, oe} !== 3'b000) begin
          n_fail++;
          $display("FAIL vblank_quiet v%0d h%0d: de/rd/oe got %b expected 000", v, h, {de, rd, oe});
        end
      end
    end
    n_checks++;
    if (gls_cnt !== 4) begin
      n_fail++;
      $display("FAIL line_start_count: got %0d expected 4", gls_cnt);
    end
    n_checks++;
    if (de_cnt !== 32) begin
      n_fail++;
      $display("FAIL de_frame_count: got %0d expected 32", de_cnt);
    end
  endtask

  task automatic test_enable_drop();
    int de_cnt = 0;
    int gls_cnt = 0;
    int fs_cnt = 0;
    int hs_low = 1;
    int h, v;
    advance_to(426);
    n_checks++;
    if (de !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_drop_de: got %b expected 1", de);
    end
    tft_on_reg = 1'b0;
    tick();
    n_checks++;
    if ({hsync, vsync, de, rd, oe} !== 5'b11000) begin
      n_fail++;
      $display("FAIL drop_truncate: got %b expected 11000", {hsync, vsync, de, rd, oe});
    end
    tick();
    tick();
    n_checks++;
    if ({hsync, vsync, de, rd, oe, gls, fs} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL drop_hold: got %b expected 1100000", {hsync, vsync, de, rd, oe, gls, fs});
    end
    tft_on_reg = 1'b1;
    tick();
    pos = 0;
    n_checks++;
    if ({hsync, vsync, fs} !== 3'b001) begin
      n_fail++;
      $display("FAIL reenable_frame_start: got %b expected 001", {hsync, vsync, fs});
    end
    for (int i = 1; i < 120; i++) begin
      tick();
      h = pos % 15;
      v = pos / 15;
      de_cnt  += de ? 1 : 0;
      gls_cnt += gls ? 1 : 0;
      fs_cnt  += fs ? 1 : 0;
      hs_low  += hsync ? 0 : 1;
      n_checks++;
      if (de !== (v >= 3 && v <= 6 && h >= 5 && h <= 12)) begin
        n_fail++;
        $display("FAIL reenable_de v%0d h%0d: got %b expected %b", v, h, de,
                 (v >= 3 && v <= 6 && h >= 5 && h <= 12));
      end
    end
    n_checks++;
    if ({de_cnt, gls_cnt, fs_cnt, hs_low} !== {32'd32, 32'd4, 32'd0, 32'd16}) begin
      n_fail++;
      $display("FAIL reenable_frame_counts: de %0d gls %0d extra_fs %0d hs_low %0d expected 32 4 0 16",
               de_cnt, gls_cnt, fs_cnt, hs_low);
    end
  endtask

  task automatic test_mid_reset();
    advance_to(171);
    n_checks++;
    if (de !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_de: got %b expected 1", de);
    end
    tft_rst_n = 1'b0;
    tick();
    n_checks++;
    if ({hsync, vsync, de, rd, oe, gls, fs} !== 7'b1100000) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b expected 1100000", {hsync, vsync, de, rd, oe, gls, fs});
    end
    tft_rst_n = 1'b1;
    tick();
    pos = 0;
    n_checks++;
    if ({hsync, fs} !== 2'b01) begin
      n_fail++;
      $display("FAIL mid_reset_restart: hsync/fs got %b expected 01", {hsync, fs});
    end
    tick();
    n_checks++;
    if ({hsync, fs} !== 2'b00) begin
      n_fail++;
      $display("FAIL mid_reset_h1: hsync/fs got %b expected 00", {hsync, fs});
    end
    tick();
    n_checks++;
    if (hsync !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reset_h2: hsync got %b expected 1", hsync);
    end
  endtask

  task automatic test_default_params();
    int hs_low = 0;
    int vs_low = 0;
    int gls_cnt = 0;
    int de_cnt = 0;
    tft_rst_n = 1'b0;
    tick();
    tft_rst_n = 1'b1;
    tick();
    pos = 0;
    n_checks++;
    if (d_fs !== 1'b1) begin
      n_fail++;
      $display("FAIL default_frame_start: got %b expected 1", d_fs);
    end
    while (pos < 28800) begin
      if (pos < 800) hs_low += d_hsync ? 0 : 1;
      vs_low += d_vsync ? 0 : 1;
      de_cnt += d_de ? 1 : 0;
      if (d_gls) begin
        gls_cnt++;
        n_checks++;
        if (pos % 800 !== 784) begin
          n_fail++;
          $display("FAIL default_line_start_h: got %0d expected 784", pos % 800);
        end
      end
      if (pos == 800 || pos == 896) begin
        n_checks++;
        if (d_hsync !== (pos == 896)) begin
          n_fail++;
          $display("FAIL default_hsync_pos%0d: got %b expected %b", pos, d_hsync, pos == 896);
        end
      end
      tick();
    end
    n_checks++;
    if ({hs_low, vs_low, gls_cnt, de_cnt} !== {32'd96, 32'd1600, 32'd2, 32'd640}) begin
      n_fail++;
      $display("FAIL default_counts: hs_low %0d vs_low %0d gls %0d de %0d expected 96 1600 2 640",
               hs_low, vs_low, gls_cnt, de_cnt);
    end
  endtask

`ifdef TFT_VSYNC_IRQ_EN
  task automatic test_vsync_irq();
    tft_rst_n = 1'b0;
    irq_ack = 1'b0;
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_reset: got %b expected 0", irq);
    end
    tft_rst_n = 1'b1;
    tick();
    pos = 0;
    n_checks++;
    if ({fs, irq} !== 2'b11) begin
      n_fail++;
      $display("FAIL irq_set: fs/irq got %b expected 11", {fs, irq});
    end
    advance_to(119);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_sticky: got %b expected 1", irq);
    end
    irq_ack = 1'b1;
    tick();
    n_checks++;
    if ({fs, irq} !== 2'b11) begin
      n_fail++;
      $display("FAIL irq_set_wins: fs/irq got %b expected 11", {fs, irq});
    end
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_ack_clear: got %b expected 0", irq);
    end
    irq_ack = 1'b0;
    advance_to(240);
    n_checks++;
    if (irq !== 1'b1) begin
      n_fail++;
      $display("FAIL irq_reset_third_frame: got %b expected 1", irq);
    end
    tft_on_reg = 1'b0;
    tick();
    n_checks++;
    if (irq !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_disable_clear: got %b expected 0", irq);
    end
    tft_on_reg = 1'b1;
  endtask
`endif

  initial begin
    tft_rst_n = 1'b0;
    tft_on_reg = 1'b1;
`ifdef TFT_VSYNC_IRQ_EN
    irq_ack = 1'b0;
    d_irq_ack = 1'b0;
`endif
    test_reset();
    test_sync();
    test_active_line();
    test_line_start();
    test_enable_drop();
    test_mid_reset();
    test_default_params();
`ifdef TFT_VSYNC_IRQ_EN
    test_vsync_irq();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
